// File: rtl/rsa_pkg.sv
// Shared types and bit positions for the RSA sequencer.
// Combinational definitions only; no timing or flow control involved.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int ST_DONE  = 0;
  localparam int ST_BUSY  = 1;
  localparam int ST_TMO   = 2;
  localparam int ST_OPERR = 3;
  localparam int ST_OVR   = 4;

  localparam int ACT_START = 0;
  localparam int ACT_ABORT = 1;

endpackage

// File: rtl/rsa_watchdog.sv
// Run-time watchdog: counts enabled cycles after a clear; expire is combinational on the last allowed cycle.
// No backpressure: the counter simply holds while en is low.
module rsa_watchdog #(
  parameter int TMO_W      = 16,
  parameter int TMO_CYCLES = 4000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYCLES - 1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/rsa_seq_ctrl.sv
// Start/abort sequencer for the modexp engine: start -> enable in 3 cycles, eoc -> result_vld/done 1 cycle later.
// No backpressure: starts while busy are dropped and flagged as overrun.
module rsa_seq_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TMO_W      = 16,
  parameter int TMO_CYCLES = 4000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             status_clr_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] e_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] const_i,
  output logic [WIDTH-1:0] rsa_p_o,
  output logic [WIDTH-1:0] rsa_e_o,
  output logic [WIDTH-1:0] rsa_m_o,
  output logic [WIDTH-1:0] rsa_const_o,
  output logic             rsa_en_o,
  output logic             rsa_rstb_o,
  input  logic             rsa_eoc_i,
  input  logic [WIDTH-1:0] rsa_c_i,
  output logic [WIDTH-1:0] result_o,
  output logic             result_vld_o,
  output logic [7:0]       status_o,
  output logic             irq_o
);

  state_t state, state_nxt;
  logic   done, tmo, operr, ovr;
  logic   set_done, set_tmo, set_operr, set_ovr, clr_run;
  logic   expire;

  rsa_watchdog #(
    .TMO_W      (TMO_W),
    .TMO_CYCLES (TMO_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == CLEAR),
    .en     (state == RUN),
    .expire (expire)
  );

  always_comb begin
    state_nxt = state;
    set_done  = 1'b0;
    set_tmo   = 1'b0;
    set_operr = 1'b0;
    clr_run   = 1'b0;
    set_ovr   = start_i && (state != IDLE);
    case (state)
      IDLE: begin
        if (start_i && !abort_i) begin
          if (p_i != '0) begin
            clr_run   = 1'b1;
            state_nxt = LOAD;
          end else begin
            set_operr = 1'b1;
          end
        end
      end
      LOAD:  state_nxt = abort_i ? IDLE : CLEAR;
      CLEAR: state_nxt = abort_i ? IDLE : RUN;
      RUN: begin
        // abort beats eoc, eoc beats the watchdog
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (rsa_eoc_i) begin
          set_done  = 1'b1;
          state_nxt = IDLE;
        end else if (expire) begin
          set_tmo   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rsa_en_o     <= 1'b0;
      rsa_rstb_o   <= 1'b0;
      rsa_p_o      <= '0;
      rsa_e_o      <= '0;
      rsa_m_o      <= '0;
      rsa_const_o  <= '0;
      result_o     <= '0;
      result_vld_o <= 1'b0;
      done         <= 1'b0;
      tmo          <= 1'b0;
      operr        <= 1'b0;
      ovr          <= 1'b0;
    end else begin
      state        <= state_nxt;
      // engine controls registered from next state so they never glitch
      rsa_en_o     <= (state_nxt == RUN);
      rsa_rstb_o   <= (state_nxt != CLEAR);
      result_vld_o <= set_done;
      if (set_done) begin
        result_o <= rsa_c_i;
      end
      if (state == LOAD) begin
        rsa_p_o     <= p_i;
        rsa_e_o     <= e_i;
        rsa_m_o     <= m_i;
        rsa_const_o <= const_i;
      end
      done  <= set_done  | (done  & ~clr_run & ~status_clr_i);
      tmo   <= set_tmo   | (tmo   & ~clr_run & ~status_clr_i);
      operr <= set_operr | (operr & ~clr_run & ~status_clr_i);
      ovr   <= set_ovr   | (ovr   & ~status_clr_i);
    end
  end

  always_comb begin
    status_o           = '0;
    status_o[ST_DONE]  = done;
    status_o[ST_BUSY]  = (state != IDLE);
    status_o[ST_TMO]   = tmo;
    status_o[ST_OPERR] = operr;
    status_o[ST_OVR]   = ovr;
  end

  assign irq_o = done | tmo | operr;

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Bench for rsa_seq_ctrl: table of modexp runs plus hand-written corner sequences.
// Engine model answers 20 cycles after enable rises; results are scoreboarded.
module tb_rsa_seq_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start_i = 1'b0, tstart = 1'b0, abort_i = 1'b0, status_clr_i = 1'b0;
  logic [W-1:0] p_i = '0, e_i = '0, m_i = '0, const_i = '0;

  logic [W-1:0] rsa_p_o, rsa_e_o, rsa_m_o, rsa_const_o, rsa_c, result_o;
  logic         rsa_en_o, rsa_rstb_o, rsa_eoc, result_vld_o, irq_o;
  logic [7:0]   status_o;

  logic [W-1:0] t_p, t_e, t_m, t_k, t_result;
  logic         t_en, t_rstb, t_vld, t_irq;
  logic [7:0]   t_status;

  int nvec = 0, nerr = 0, vld_cnt = 0, t_vld_cnt = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  rsa_seq_ctrl #(.WIDTH(W), .TMO_W(16), .TMO_CYCLES(40)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .status_clr_i(status_clr_i), .p_i(p_i), .e_i(e_i), .m_i(m_i), .const_i(const_i),
    .rsa_p_o(rsa_p_o), .rsa_e_o(rsa_e_o), .rsa_m_o(rsa_m_o), .rsa_const_o(rsa_const_o),
    .rsa_en_o(rsa_en_o), .rsa_rstb_o(rsa_rstb_o), .rsa_eoc_i(rsa_eoc), .rsa_c_i(rsa_c),
    .result_o(result_o), .result_vld_o(result_vld_o), .status_o(status_o), .irq_o(irq_o)
  );

  rsa_seq_ctrl #(.WIDTH(W), .TMO_W(16), .TMO_CYCLES(10)) dut_t (
    .clk(clk), .rst_n(rst_n), .start_i(tstart), .abort_i(abort_i),
    .status_clr_i(status_clr_i), .p_i(p_i), .e_i(e_i), .m_i(m_i), .const_i(const_i),
    .rsa_p_o(t_p), .rsa_e_o(t_e), .rsa_m_o(t_m), .rsa_const_o(t_k),
    .rsa_en_o(t_en), .rsa_rstb_o(t_rstb), .rsa_eoc_i(1'b0), .rsa_c_i('0),
    .result_o(t_result), .result_vld_o(t_vld), .status_o(t_status), .irq_o(t_irq)
  );

  function automatic logic [7:0] modexp(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m);
    logic [15:0] r, b, pp;
    if (p == 8'd0) return 8'd0;
    pp = {8'h00, p};
    r  = (p == 8'd1) ? 16'd0 : 16'd1;
    b  = {8'h00, m} % pp;
    for (int i = 0; i < int'(e); i++) r = (r * b) % pp;
    return r[7:0];
  endfunction

  // behavioural engine: one eoc pulse 20 cycles after enable rises, even if enable drops meanwhile
  logic [5:0] ecnt = 6'd0;
  logic       en_prev = 1'b0;
  always @(posedge clk) begin
    en_prev <= rsa_en_o;
    if (ecnt != 6'd0) ecnt <= (ecnt == 6'd20) ? 6'd0 : ecnt + 6'd1;
    else if (rsa_en_o && !en_prev) ecnt <= 6'd1;
  end
  assign rsa_eoc = (ecnt == 6'd20);
  assign rsa_c   = modexp(rsa_p_o, rsa_e_o, rsa_m_o);

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (t_vld) t_vld_cnt++;
    if (result_vld_o) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_result: got 0x%0h, no result expected", result_o);
      end else begin
        chk("result", 16'(result_o), 16'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_vld(input string nm);
    int n = 0;
    while (!result_vld_o && n < 100) begin @(negedge clk); n++; end
    if (!result_vld_o) begin nvec++; nerr++; $display("FAIL %s: result_vld_o never rose", nm); end
  endtask

  task automatic wait_en(input string nm);
    int n = 0;
    while (!rsa_en_o && n < 20) begin @(negedge clk); n++; end
    if (!rsa_en_o) begin nvec++; nerr++; $display("FAIL %s: rsa_en_o never rose", nm); end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic pulse_clr();
    status_clr_i = 1'b1;
    @(negedge clk);
    status_clr_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0] p, e, m, k, c;
  } vec_t;
  vec_t tv[6];

  task automatic run_vec(input vec_t v);
    p_i = v.p; e_i = v.e; m_i = v.m; const_i = v.k;
    exp_q.push_back(v.c);
    pulse_start();
    chk("load_status", 16'(status_o), 16'h02);
    chk("load_en", 16'(rsa_en_o), 16'd0);
    @(negedge clk);
    chk("clear_rstb", 16'(rsa_rstb_o), 16'd0);
    @(negedge clk);
    chk("run_en", 16'(rsa_en_o), 16'd1);
    chk("run_rstb", 16'(rsa_rstb_o), 16'd1);
    chk("op_p", 16'(rsa_p_o), 16'(v.p));
    chk("op_m", 16'(rsa_m_o), 16'(v.m));
    chk("op_const", 16'(rsa_const_o), 16'(v.k));
    wait_vld("run_vec");
    chk("done_status", 16'(status_o), 16'h01);
    chk("done_irq", 16'(irq_o), 16'd1);
    @(negedge clk);
    chk("vld_pulse", 16'(result_vld_o), 16'd0);
  endtask

  initial begin
    int v0, cnt;
    tv[0] = '{p: 8'd187, e: 8'd7, m: 8'd88,  k: 8'h5A, c: 8'd11};
    tv[1] = '{p: 8'd11,  e: 8'd3, m: 8'd2,   k: 8'h01, c: 8'd8};
    tv[2] = '{p: 8'd255, e: 8'd0, m: 8'd77,  k: 8'hFF, c: 8'd1};
    tv[3] = '{p: 8'd1,   e: 8'd5, m: 8'd9,   k: 8'h00, c: 8'd0};
    tv[4] = '{p: 8'd13,  e: 8'd2, m: 8'd5,   k: 8'h3C, c: 8'd12};
    tv[5] = '{p: 8'd200, e: 8'd1, m: 8'd250, k: 8'hA5, c: 8'd50};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rstb", 16'(rsa_rstb_o), 16'd0);
    chk("rst_en", 16'(rsa_en_o), 16'd0);
    chk("rst_status", 16'(status_o), 16'h00);
    chk("rst_irq", 16'(irq_o), 16'd0);
    chk("rst_vld", 16'(result_vld_o), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rstb", 16'(rsa_rstb_o), 16'd1);

    for (int i = 0; i < 6; i++) run_vec(tv[i]);

    // watchdog on the short-timeout instance, whose engine never answers
    p_i = 8'd5; e_i = 8'd3; m_i = 8'd2;
    tstart = 1'b1; @(negedge clk); tstart = 1'b0;
    cnt = 0;
    while (!t_en && cnt < 20) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (t_en && cnt < 50) begin @(negedge clk); cnt++; end
    chk("tmo_run_cycles", 16'(cnt), 16'd10);
    chk("tmo_status", 16'(t_status), 16'h04);
    chk("tmo_irq", 16'(t_irq), 16'd1);
    chk("tmo_no_vld", 16'(t_vld_cnt), 16'd0);

    // operand error, clear, and clear losing to a same-cycle set
    p_i = 8'd0;
    pulse_start();
    chk("operr_status", 16'(status_o), 16'h09);
    chk("operr_irq", 16'(irq_o), 16'd1);
    repeat (2) @(negedge clk);
    chk("operr_idle", 16'(status_o), 16'h09);
    chk("operr_en", 16'(rsa_en_o), 16'd0);
    pulse_clr();
    chk("clr_status", 16'(status_o), 16'h00);
    chk("clr_irq", 16'(irq_o), 16'd0);
    start_i = 1'b1; status_clr_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; status_clr_i = 1'b0;
    chk("set_beats_clr", 16'(status_o), 16'h08);
    pulse_clr();

    // abort suppresses a same-cycle start in IDLE
    p_i = 8'd187; e_i = 8'd7; m_i = 8'd88;
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    chk("abort_beats_start", 16'(status_o), 16'h00);

    // overrun while running; operand writes must not reach the engine
    exp_q.push_back(8'd11);
    pulse_start();
    wait_en("ovr");
    repeat (5) @(negedge clk);
    m_i = 8'd5;
    pulse_start();
    chk("ovr_m_stable", 16'(rsa_m_o), 16'd88);
    wait_vld("ovr");
    chk("ovr_status", 16'(status_o), 16'h11);
    @(negedge clk);
    pulse_clr();
    chk("ovr_clr", 16'(status_o), 16'h00);

    // abort mid-run; the engine's late eoc must be ignored
    m_i = 8'd88;
    v0 = vld_cnt;
    pulse_start();
    wait_en("abort");
    repeat (5) @(negedge clk);
    abort_i = 1'b1; @(negedge clk); abort_i = 1'b0;
    chk("abort_en", 16'(rsa_en_o), 16'd0);
    chk("abort_status", 16'(status_o), 16'h00);
    repeat (30) @(negedge clk);
    chk("abort_no_vld", 16'(vld_cnt - v0), 16'd0);
    chk("abort_late_eoc", 16'(status_o), 16'h00);

    // abort and eoc in the same cycle
    v0 = vld_cnt;
    pulse_start();
    cnt = 0;
    while (!rsa_eoc && cnt < 60) begin @(negedge clk); cnt++; end
    chk("sim_eoc_seen", 16'(rsa_eoc), 16'd1);
    abort_i = 1'b1; @(negedge clk); abort_i = 1'b0;
    chk("sim_status", 16'(status_o), 16'h00);
    chk("sim_en", 16'(rsa_en_o), 16'd0);
    @(negedge clk);
    chk("sim_no_vld", 16'(vld_cnt - v0), 16'd0);

    // reset mid-run
    repeat (25) @(negedge clk);
    pulse_start();
    wait_en("rst_mid");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rstb", 16'(rsa_rstb_o), 16'd0);
    chk("mid_en", 16'(rsa_en_o), 16'd0);
    chk("mid_status", 16'(status_o), 16'h00);
    chk("mid_result", 16'(result_o), 16'd0);
    chk("mid_op_p", 16'(rsa_p_o), 16'd0);
    repeat (2) @(negedge clk);
    chk("mid_rstb_hold", 16'(rsa_rstb_o), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_recover_rstb", 16'(rsa_rstb_o), 16'd1);
    repeat (25) @(negedge clk);
    run_vec(tv[0]);

    repeat (3) @(negedge clk);
    chk("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "bench timeout");
  end

endmodule
